ef_apb_master: RTL and testbench
================================

EF_APB_MASTER -- requirements
Module: ef_apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of ACCESS cycles with PREADY low before abort (0 = no timeout, legal range 0..65535).
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports:
- PCLK  in  1  clock; all state changes on its rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  command request valid.
- req_ready  out  1  command accepted when req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  target address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  32  read data.
- rsp_err  out  1  slave error or timeout.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB slave ready.
- PSLVERR  in  1  APB slave error.

Function
REQ-003 SHALL implement an FSM with the states IDLE, SETUP, ACCESS and RESP; all outputs SHALL be registered or decoded from the state.
REQ-004 req_ready SHALL be 1 only in IDLE; when req_valid=1 in IDLE, the block SHALL latch req_write, req_addr and req_wdata (reads latch wdata as 0) and move to SETUP.
REQ-005 In SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched values; next state SHALL be ACCESS unconditionally.
REQ-006 In ACCESS: PSEL=1 and PENABLE=1, and PADDR/PWRITE/PWDATA SHALL remain unchanged from SETUP.
REQ-007 In ACCESS with PREADY=1, the block SHALL:
- capture rsp_rdata = PRDATA for reads, or 0 for writes;
- capture rsp_err = PSLVERR;
- clear the wait counter;
- move to RESP, with PSEL=0 and PENABLE=0 from the next cycle.
REQ-008 In ACCESS with PREADY=0, a 16-bit wait counter SHALL increment each cycle.
REQ-009 When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with PREADY still 0, the block SHALL abort:
- move to RESP;
- rsp_err=1, rsp_rdata=32'hDEADBEEF;
- PSEL=0, PENABLE=0 on the next cycle.
REQ-010 PREADY=1 in the same cycle the counter reaches the limit SHALL count as normal completion (REQ-007), not as a timeout.
REQ-011 PREADY and PSLVERR SHALL be ignored outside ACCESS.
REQ-012 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL hold stable until rsp_ready=1; the FSM then returns to IDLE, and rsp_valid=0 from the next cycle.
REQ-013 Latency: request accepted at edge N gives SETUP in cycle N+1 and ACCESS in N+2; with PREADY=1 in N+2, rsp_valid=1 in N+3. Each extra PREADY-low cycle adds one cycle.
REQ-014 Minimum spacing between accepted requests SHALL be 4 cycles; no new request SHALL be accepted while a response is pending.
REQ-015 In IDLE, PADDR/PWRITE/PWDATA SHALL hold their last driven values, and PSEL and PENABLE SHALL be 0.
REQ-016 PENABLE=1 SHALL never occur without PSEL=1, and never in the first cycle of a transfer.

Reset
REQ-017 When PRESETn=0, the block SHALL asynchronously force state=IDLE and the following outputs and state:
- PSEL=0, PENABLE=0, PWRITE=0;
- PADDR=0, PWDATA=0;
- rsp_valid=0, rsp_rdata=0, rsp_err=0;
- req_ready=0 while reset is asserted;
- wait counter=0.
REQ-018 Reset asserted mid-transaction (SETUP, ACCESS or RESP) SHALL discard the transaction with no response produced; req_ready SHALL become 1 on the first PCLK edge after release.

Verification
REQ-019 The bench SHALL cover:
- Write 0x10<-0xA5A5_0001, PREADY tied 1 -> SETUP then ACCESS with PADDR=0x10, PWDATA=0xA5A50001, PWRITE=1; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read 0x04, PREADY low 3 ACCESS cycles, PRDATA=0x1234_5678 -> PENABLE high 4 cycles, address stable throughout; rsp_rdata=0x12345678 one cycle after PREADY.
- Read with PSLVERR=1 at PREADY, then rsp_ready held 0 for 5 cycles -> rsp_err=1, response stable 5 cycles, req_ready=0 until consumed.
- TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 ACCESS cycles; rsp_err=1, rsp_rdata=0xDEADBEEF, PSEL=0; a later request completes normally.
- Back-to-back req_valid with rsp_ready=1 -> accepts spaced exactly 4 cycles; PRESETn pulsed low during ACCESS -> PSEL=0 immediately, no rsp_valid, new request accepted after release.

Source files
------------

// File: rtl/ef_apb_master.sv
// Single-outstanding APB master: turns a valid/ready command into one APB
// transfer and returns the read data or error through a valid/ready response.
module ef_apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

    state_t      state;
    state_t      next_state;
    logic [15:0] wait_cnt;
    logic [16:0] wait_cnt_inc;
    logic        accept;
    logic        xfer_done;
    logic        timeout_hit;

    // One extra bit keeps the compare exact even for TIMEOUT_CYCLES = 65535.
    assign wait_cnt_inc = {1'b0, wait_cnt} + 17'd1;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        xfer_done   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                accept = req_valid && req_ready;
                if (accept) next_state = SETUP;
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                // PREADY on the limit cycle wins: that is a completion, not an abort.
                xfer_done   = PREADY;
                timeout_hit = !PREADY && (TIMEOUT_CYCLES != 0) &&
                              (wait_cnt_inc == TIMEOUT_LIMIT);
                if (xfer_done || timeout_hit) next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= next_state;
    end

    // Handshake and APB strobes are registered from the next state so they
    // line up with the state they describe and never glitch.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            req_ready <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            req_ready <= (next_state == IDLE);
            PSEL      <= (next_state == SETUP) || (next_state == ACCESS);
            PENABLE   <= (next_state == ACCESS);
            rsp_valid <= (next_state == RESP);
        end
    end

    // Command capture; the APB address/data hold their last values in IDLE.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else if (accept) begin
            PADDR  <= req_addr;
            PWRITE <= req_write;
            PWDATA <= req_write ? req_wdata : 32'd0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (accept || xfer_done || timeout_hit) begin
            wait_cnt <= '0;
        end else if (state == ACCESS) begin
            wait_cnt <= wait_cnt_inc[15:0];
        end
    end

    // Response registers load once per transfer and then hold through RESP.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (xfer_done) begin
            rsp_rdata <= PWRITE ? 32'd0 : PRDATA;
            rsp_err   <= PSLVERR;
        end else if (timeout_hit) begin
            rsp_rdata <= TIMEOUT_RDATA;
            rsp_err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ef_apb_master.sv
// Randomized self-checking bench for ef_apb_master, with a transaction-level
// reference model of latency, APB phases and response contents.
module tb_ef_apb_master;

    localparam int TO = 4;

    logic        PCLK;
    logic        PRESETn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int vec_cnt = 0;
    int err_cnt = 0;

    ef_apb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: ACCESS lasts until PREADY, or TO low cycles when the slave stalls.
    function automatic int model_access_cycles(input int waits);
        if (TO != 0 && waits >= TO) return TO;
        return waits + 1;
    endfunction

    task automatic slave_noise();
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
    endtask

    // One full transaction. waits = PREADY-low ACCESS cycles before PREADY,
    // hold = cycles rsp_ready stays low once the response is up.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic slverr, input logic [31:0] rdata,
                           input int hold);
        int          t;
        int          lat;
        int          acc;
        bit          timed_out;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_wd;

        timed_out = (TO != 0 && waits >= TO);
        exp_wd    = wr ? wdata : 32'd0;
        exp_rd    = timed_out ? 32'hDEAD_BEEF : (wr ? 32'd0 : rdata);
        exp_err   = timed_out ? 1'b1 : slverr;

        t = 0;
        while (!req_ready && t < 20) begin
            slave_noise();
            @(negedge PCLK);
            t++;
        end
        check("req_ready_idle", req_ready, 1'b1);
        check("psel_idle", PSEL, 1'b0);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        slave_noise();
        @(negedge PCLK);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;

        check("setup_psel", PSEL, 1'b1);
        check("setup_penable", PENABLE, 1'b0);
        check("setup_paddr", PADDR, addr);
        check("setup_pwrite", PWRITE, wr);
        check("setup_pwdata", PWDATA, exp_wd);
        check("setup_req_ready", req_ready, 1'b0);

        lat = 1;
        acc = 0;
        while (!rsp_valid && lat < 40) begin
            if (PSEL && PENABLE) begin
                if (PADDR !== addr || PWRITE !== wr || PWDATA !== exp_wd)
                    check("access_stable", {PADDR[30:0], PWRITE}, {addr[30:0], wr});
                PREADY  = (acc == waits);
                PSLVERR = (acc == waits) ? slverr : 1'($urandom);
                PRDATA  = (acc == waits) ? rdata : $urandom;
                acc++;
            end else begin
                if (PENABLE) check("penable_without_psel", PSEL, 1'b1);
                slave_noise();
            end
            @(negedge PCLK);
            lat++;
        end
        check("rsp_valid_seen", rsp_valid, 1'b1);
        check("access_cycles", acc, model_access_cycles(waits));
        check("rsp_latency", lat, 2 + model_access_cycles(waits));

        for (int i = 0; i <= hold; i++) begin
            rsp_ready = (i == hold);
            slave_noise();
            check("rsp_valid_hold", rsp_valid, 1'b1);
            check("rsp_rdata", rsp_rdata, exp_rd);
            check("rsp_err", rsp_err, exp_err);
            check("resp_req_ready", req_ready, 1'b0);
            check("resp_psel", {PSEL, PENABLE}, 2'b00);
            @(negedge PCLK);
        end
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 1'b0);
        check("req_ready_back", req_ready, 1'b1);
        check("idle_paddr_hold", PADDR, addr);
    endtask

    initial begin
        int accepts[$];
        int t;

        PRESETn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        #12;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_apb", {PSEL, PENABLE, PWRITE}, 3'b000);
        check("rst_paddr", PADDR, 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
        check("rst_rdata", rsp_rdata, 32'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Directed: plain write, stalled read, slave error with response backpressure, timeout.
        run_txn(1'b1, 32'h10, 32'hA5A5_0001, 0, 1'b0, 32'hFFFF_0000, 0);
        run_txn(1'b0, 32'h04, 32'h0, 3, 1'b0, 32'h1234_5678, 0);
        run_txn(1'b0, 32'h20, 32'h0, 1, 1'b1, 32'hCAFE_0001, 5);
        run_txn(1'b0, 32'h30, 32'h0, 100, 1'b0, 32'h5555_AAAA, 1);
        run_txn(1'b0, 32'h34, 32'h0, TO - 1, 1'b0, 32'h0BAD_F00D, 0);
        run_txn(1'b1, 32'h38, 32'h7777_8888, 2, 1'b0, 32'h1, 0);

        for (int n = 0; n < 30; n++) begin
            run_txn(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 6)),
                    1'($urandom), $urandom, int'($urandom_range(0, 3)));
        end

        // Back-to-back requests with a zero-wait slave and an always-ready consumer.
        for (int i = 0; i < 17; i++) begin
            req_valid = 1'b1;
            req_write = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            rsp_ready = 1'b1;
            PREADY    = 1'b1;
            PSLVERR   = 1'b0;
            PRDATA    = $urandom;
            if (req_ready) accepts.push_back(i);
            @(negedge PCLK);
        end
        req_valid = 1'b0;
        check("b2b_accept_count", accepts.size(), 5);
        for (int i = 1; i < accepts.size(); i++)
            check("b2b_spacing", accepts[i] - accepts[i-1], 4);
        t = 0;
        while (!req_ready && t < 10) begin
            @(negedge PCLK);
            t++;
        end
        rsp_ready = 1'b0;
        check("b2b_drain", {req_ready, rsp_valid}, 2'b10);

        // Reset in the middle of a stalled ACCESS phase.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h44;
        req_wdata = 32'h1111_2222;
        PREADY    = 1'b0;
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("pre_rst_access", {PSEL, PENABLE}, 2'b11);
        #2;
        PRESETn = 1'b0;
        #1;
        check("mid_rst_apb", {PSEL, PENABLE}, 2'b00);
        check("mid_rst_req_ready", req_ready, 1'b0);
        check("mid_rst_paddr", PADDR, 32'd0);
        @(negedge PCLK);
        check("mid_rst_rsp", rsp_valid, 1'b0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("post_rst_ready", req_ready, 1'b1);
        check("post_rst_rsp", rsp_valid, 1'b0);
        run_txn(1'b0, 32'h48, 32'h0, 1, 1'b0, 32'h9ABC_DEF0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
